overlap_framer: RTL
===================

Name: overlap_framer

Overview:
- Streaming front end of the MFCC pipeline, upstream of fft.
- Parametrised successor to the fixed non-overlapping framing block: frame size and hop size are parameters, frames overlap, and a Hamming window is applied to every emitted sample.
- Uses valid/ready on both sides, so downstream FFT stalls propagate back to the audio source.
- Emits frames oldest-sample-first, with start/last markers.

Parameters:
- DATA_WIDTH, 16, signed sample width (two's complement).
- FRAME_SIZE, 8, samples per frame; power of two, at least 4.
- HOP_SIZE, 4, new samples between frame starts; 1 ≤ HOP_SIZE ≤ FRAME_SIZE.
- COEF_WIDTH, 16, unsigned window coefficient width, Q1.(COEF_WIDTH-1).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- audio_in  in  DATA_WIDTH  signed input sample.
- valid_in  in  1  audio_in valid.
- ready_in  out  1  block accepts a sample this cycle.
- windowed_out  out  DATA_WIDTH  signed windowed sample.
- valid_out  out  1  windowed_out valid.
- ready_out  in  1  downstream accepts windowed_out.
- frame_start  out  1  qualifies the first sample of a frame (meaningful only with valid_out).
- frame_last  out  1  qualifies the last sample of a frame.
- overrun  out  1  one-cycle pulse: valid_in asserted while ready_in low; that sample is dropped.

Behaviour:
- Reset (async, immediate): all outputs 0; FSM to FILL; pointers and counters 0; any partial frame is discarded. Buffer contents are don't-care.
- Storage: circular buffer of FRAME_SIZE samples.
  - wr_ptr wraps modulo FRAME_SIZE.
  - Oldest sample is at wr_ptr when entering EMIT.
- Input transfer occurs on valid_in && ready_in. The sample is written at wr_ptr, then wr_ptr increments.
- FSM:
  - FILL: ready_in=1. Counts accepted samples. At the FRAME_SIZE-th transfer, go to EMIT.
  - EMIT: ready_in=0. rd_idx runs 0..FRAME_SIZE-1. Each sample is read from buffer[(wr_ptr+rd_idx) mod FRAME_SIZE], windowed, and loaded into the output register. When the last sample is accepted downstream, go to HOP.
  - HOP: ready_in=1. Counts accepted samples. At the HOP_SIZE-th transfer, go to EMIT.
- Output register:
  - Loads when empty (valid_out=0) or being consumed (valid_out && ready_out) and the FSM has a sample to issue.
  - While valid_out && !ready_out, windowed_out, frame_start and frame_last hold stable. No sample is lost or duplicated.
- Latency: the first valid_out is asserted the cycle after the transition into EMIT. At full throughput (ready_out=1), one sample is emitted per cycle, so a frame takes FRAME_SIZE cycles.
- Windowing:
  - w[n] = 0.54 − 0.46·cos(2πn/(FRAME_SIZE−1)), quantised to Q1.15, round to nearest, clipped to 2^(COEF_WIDTH−1)−1.
  - Product is signed sample × unsigned coef, with full-width intermediate.
  - Result = (product + 2^(COEF_WIDTH−2)) >>> (COEF_WIDTH−1), truncated to DATA_WIDTH. The result always fits because w < 1.
- overrun: registered pulse, asserted in the cycle after the offending valid_in. The FSM and pointers are unaffected.
- Simultaneous events:
  - The last EMIT handshake and the HOP transition happen in the same edge.
  - valid_in arriving in that same cycle is not accepted, because ready_in is still 0 in that cycle.
- Steady state: one frame is emitted per HOP_SIZE accepted samples.

Optional Feature:
- Macro: OVERLAP_FRAMER_WINDOW_EN.
- Defined: Hamming window applied as above; window_coef_rom is instantiated.
- Undefined: rectangular window. windowed_out equals the buffered sample exactly. No multiplier or ROM is instantiated; latency and handshake are unchanged.

Decomposition:
- Shared package mfcc_pkg:
  - default DATA_WIDTH and COEF_WIDTH;
  - FSM state encoding (FILL=0, EMIT=1, HOP=2);
  - clog2 constant function used for pointer widths.
- One sub-module, window_coef_rom:
  - parameters FRAME_SIZE, COEF_WIDTH;
  - combinational index-to-coef lookup;
  - table built as an elaboration-time constant.

Test Plan:
- Rectangular (macro undefined), FRAME_SIZE=8, HOP_SIZE=4, ready_out=1, ramp 1..16 continuous → three frames: 1..8, 5..12, 9..16. frame_start on 1, 5, 9; frame_last on 8, 12, 16.
- Windowed (macro defined), constant input 0x4000 for 8 samples → first output 1311 (w[0]=2621); output sequence symmetric, w[n]=w[7−n].
- Backpressure: ramp as in test 1, ready_out low for 3 cycles mid-frame at sample 3 → windowed_out=3 held 3 cycles; full sequence unchanged, no drops or duplicates.
- Overrun: valid_in held high with ramp through EMIT → one overrun pulse per sample offered during EMIT; the next frame reflects only accepted samples.
- Reset mid-EMIT: assert rst at the 4th output sample → valid_out, ready_in, frame_start/last and overrun all 0 immediately. After release, no output until 8 new samples are accepted.
- HOP_SIZE=FRAME_SIZE=8, ramp 1..24 → non-overlapping frames 1..8, 9..16, 17..24.

Source files
------------

// File: rtl/mfcc_pkg.sv
// Shared definitions for the MFCC front end: default widths, framer state
// encoding and the log2 helper used to size pointers.
package mfcc_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_COEF_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_EMIT = 2'd1,
        ST_HOP  = 2'd2
    } framer_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/window_coef_rom.sv
// Hamming window lookup, Q1.(COEF_WIDTH-1), table fixed at elaboration.
// Only instantiated when OVERLAP_FRAMER_WINDOW_EN is defined.
module window_coef_rom
    import mfcc_pkg::*;
#(
    parameter int FRAME_SIZE = 8,
    parameter int COEF_WIDTH = DEFAULT_COEF_WIDTH,
    localparam int IW = clog2(FRAME_SIZE)
) (
    input  logic [IW-1:0]         idx,
    output logic [COEF_WIDTH-1:0] coef
);

    // Cosine by Taylor series after folding the angle into [-pi, pi], so the
    // table does not depend on tool support for real math system functions.
    function automatic logic [COEF_WIDTH-1:0] hamming_coef(input int n);
        real pi;
        real x;
        real term;
        real c;
        real scaled;
        real max_c;
        pi = 3.14159265358979323846;
        x = 2.0 * pi * n / (FRAME_SIZE - 1);
        if (x > pi) x = x - 2.0 * pi;
        c = 1.0;
        term = 1.0;
        for (int k = 1; k <= 14; k++) begin
            term = -term * x * x / ((2 * k - 1) * (2 * k));
            c = c + term;
        end
        scaled = (0.54 - 0.46 * c) * (2.0 ** (COEF_WIDTH - 1));
        max_c = (2.0 ** (COEF_WIDTH - 1)) - 1.0;
        if (scaled > max_c) scaled = max_c;
        return COEF_WIDTH'($rtoi(scaled + 0.5));
    endfunction

    logic [COEF_WIDTH-1:0] coef_tab [FRAME_SIZE];

    for (genvar i = 0; i < FRAME_SIZE; i++) begin : g_tab
        localparam logic [COEF_WIDTH-1:0] COEF_I = hamming_coef(i);
        assign coef_tab[i] = COEF_I;
    end

    assign coef = coef_tab[idx];

endmodule

// File: rtl/overlap_framer.sv
// Overlapping framer with valid/ready on both sides; emits frames oldest-first.
// OVERLAP_FRAMER_WINDOW_EN selects Hamming windowing, otherwise rectangular.
//
// state | meaning
// FILL  | collecting the first FRAME_SIZE samples after reset
// EMIT  | streaming the buffered frame out, input stalled
// HOP   | collecting HOP_SIZE fresh samples before the next frame
module overlap_framer
    import mfcc_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FRAME_SIZE = 8,
    parameter int HOP_SIZE   = 4,
    parameter int COEF_WIDTH = DEFAULT_COEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] audio_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] windowed_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  frame_start,
    output logic                  frame_last,
    output logic                  overrun
);

    localparam int PW = clog2(FRAME_SIZE);
    localparam logic [PW-1:0] FILL_LAST = PW'(FRAME_SIZE - 1);
    localparam logic [PW-1:0] HOP_LAST  = PW'(HOP_SIZE - 1);
    localparam logic [PW-1:0] IDX_LAST  = PW'(FRAME_SIZE - 1);

    framer_state_e         state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_idx_q, rd_idx_d;
    logic [PW-1:0]         cnt_q, cnt_d;
    logic                  issued_all_q, issued_all_d;
    logic                  ready_in_q, ready_in_d;
    logic                  valid_out_q, valid_out_d;
    logic                  frame_start_q, frame_start_d;
    logic                  frame_last_q, frame_last_d;
    logic                  overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0] windowed_q, windowed_d;
    logic [DATA_WIDTH-1:0] buf_q [FRAME_SIZE];

    logic                  in_xfer;
    logic                  out_xfer;
    logic [PW-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0] rd_sample;
    logic [DATA_WIDTH-1:0] win_sample;

    assign in_xfer   = valid_in && ready_in_q;
    assign out_xfer  = valid_out_q && ready_out;
    assign rd_addr   = wr_ptr_q + rd_idx_q;
    assign rd_sample = buf_q[rd_addr];

`ifdef OVERLAP_FRAMER_WINDOW_EN
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH + 1;
    localparam logic signed [PROD_W-1:0] HALF = PROD_W'(1) << (COEF_WIDTH - 2);

    logic [COEF_WIDTH-1:0]    coef;
    logic signed [PROD_W-1:0] product;
    logic signed [PROD_W-1:0] rounded;

    window_coef_rom #(
        .FRAME_SIZE (FRAME_SIZE),
        .COEF_WIDTH (COEF_WIDTH)
    ) u_coef_rom (
        .idx  (rd_idx_q),
        .coef (coef)
    );

    // Coefficient gets a zero sign bit so the multiply stays signed x unsigned.
    assign product    = PROD_W'($signed(rd_sample)) * PROD_W'($signed({1'b0, coef}));
    assign rounded    = product + HALF;
    assign win_sample = DATA_WIDTH'(rounded >>> (COEF_WIDTH - 1));
`else
    assign win_sample = rd_sample;
`endif

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_idx_d      = rd_idx_q;
        cnt_d         = cnt_q;
        issued_all_d  = issued_all_q;
        valid_out_d   = valid_out_q;
        windowed_d    = windowed_q;
        frame_start_d = frame_start_q;
        frame_last_d  = frame_last_q;
        overrun_d     = valid_in && !ready_in_q;

        if (in_xfer) wr_ptr_d = wr_ptr_q + PW'(1);

        case (state_q)
            ST_FILL, ST_HOP: begin
                if (in_xfer) begin
                    if (cnt_q == ((state_q == ST_FILL) ? FILL_LAST : HOP_LAST)) begin
                        cnt_d   = '0;
                        state_d = ST_EMIT;
                    end else begin
                        cnt_d = cnt_q + PW'(1);
                    end
                end
            end
            ST_EMIT: begin
                if (!issued_all_q && (!valid_out_q || ready_out)) begin
                    valid_out_d   = 1'b1;
                    windowed_d    = win_sample;
                    frame_start_d = (rd_idx_q == '0);
                    frame_last_d  = (rd_idx_q == IDX_LAST);
                    rd_idx_d      = rd_idx_q + PW'(1);
                    if (rd_idx_q == IDX_LAST) issued_all_d = 1'b1;
                end else if (out_xfer) begin
                    valid_out_d   = 1'b0;
                    frame_start_d = 1'b0;
                    frame_last_d  = 1'b0;
                    // Last sample of the frame just left: reopen the input.
                    if (issued_all_q) begin
                        issued_all_d = 1'b0;
                        state_d      = ST_HOP;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase

        ready_in_d = (state_d != ST_EMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FILL;
            wr_ptr_q      <= '0;
            rd_idx_q      <= '0;
            cnt_q         <= '0;
            issued_all_q  <= 1'b0;
            ready_in_q    <= 1'b0;
            valid_out_q   <= 1'b0;
            windowed_q    <= '0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_idx_q      <= rd_idx_d;
            cnt_q         <= cnt_d;
            issued_all_q  <= issued_all_d;
            ready_in_q    <= ready_in_d;
            valid_out_q   <= valid_out_d;
            windowed_q    <= windowed_d;
            frame_start_q <= frame_start_d;
            frame_last_q  <= frame_last_d;
            overrun_q     <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_xfer) buf_q[wr_ptr_q] <= audio_in;
    end

    assign ready_in     = ready_in_q;
    assign valid_out    = valid_out_q;
    assign windowed_out = windowed_q;
    assign frame_start  = frame_start_q;
    assign frame_last   = frame_last_q;
    assign overrun      = overrun_q;

endmodule
